// File: rtl/tx_link_sequencer.sv
// PIPE transmit sequencer: idle -> detect -> TS1 training or compliance -> L0 with periodic SKP sets.
// Outputs registered (user symbol latency 1); user_ready is withheld on the pre-SKP slot and during SKP.
module tx_link_sequencer #(
  parameter int DETECT_CYCLES = 8,
  parameter int RETRY_CYCLES  = 32,
  parameter int TS1_COUNT     = 16,
  parameter int SKP_INTERVAL  = 128
) (
  input  logic       TXCLK,
  input  logic       Reset,
  input  logic       link_en,
  input  logic       cfg_compliance,
  input  logic       cfg_loopback,
  input  logic       RXDET_O,
  input  logic [7:0] user_data,
  input  logic       user_datak,
  input  logic       user_valid,
  output logic       user_ready,
  output logic [7:0] TXDATA,
  output logic       TXDATAK,
  output logic       TXCOMP,
  output logic       TXIDLE,
  output logic       RXDET,
  output logic       RXLOOPB,
  output logic       link_up,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_ELEC_IDLE  = 3'd0,
    S_DETECT     = 3'd1,
    S_TRAIN      = 3'd2,
    S_COMPLIANCE = 3'd3,
    S_L0         = 3'd4,
    S_SKP        = 3'd5
  } state_t;

  localparam logic [15:0] RETRY_LAST  = 16'(RETRY_CYCLES - 1);
  localparam logic [15:0] DETECT_LAST = 16'(DETECT_CYCLES - 1);
  localparam logic [15:0] TRAIN_LAST  = 16'(TS1_COUNT * 16 - 1);
  localparam logic [15:0] SKP_LAST    = 16'(SKP_INTERVAL - 1);

  state_t      st_q, st_d;
  logic [15:0] cnt_q, cnt_d, skp_q, skp_d;
  logic [7:0]  data_d;
  logic        datak_d, comp_d, idle_d, rxdet_d, loopb_d, up_d;
  logic        accept;

  assign state      = st_q;
  assign user_ready = (st_q == S_L0) && (skp_q != SKP_LAST);
  assign accept     = user_valid && user_ready;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    skp_d = skp_q;
    if (!link_en) begin
      st_d  = S_ELEC_IDLE;
      cnt_d = '0;
      skp_d = '0;
    end else begin
      case (st_q)
        S_ELEC_IDLE: begin
          if (cnt_q == RETRY_LAST) begin
            st_d  = S_DETECT;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_DETECT: begin
          if (cnt_q == DETECT_LAST) begin
            cnt_d = '0;
            if (!RXDET_O)           st_d = S_ELEC_IDLE;
            else if (cfg_compliance) st_d = S_COMPLIANCE;
            else                     st_d = S_TRAIN;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_TRAIN: begin
          if (cnt_q == TRAIN_LAST) begin
            st_d  = S_L0;
            cnt_d = '0;
            skp_d = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        // Only the pattern phase matters, so the counter stays within 0..3.
        S_COMPLIANCE: cnt_d = {14'd0, cnt_q[1:0] + 2'd1};
        S_L0: begin
          if (skp_q == SKP_LAST) begin
            st_d  = S_SKP;
            cnt_d = '0;
            skp_d = '0;
          end else begin
            skp_d = skp_q + 16'd1;
          end
        end
        S_SKP: begin
          if (cnt_q == 16'd3) begin
            st_d  = S_L0;
            cnt_d = '0;
            skp_d = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          st_d  = S_ELEC_IDLE;
          cnt_d = '0;
          skp_d = '0;
        end
      endcase
    end
  end

  // Output values are decoded from the upcoming state so they align with it.
  always_comb begin
    data_d  = 8'h00;
    datak_d = 1'b0;
    comp_d  = 1'b0;
    idle_d  = 1'b1;
    rxdet_d = 1'b0;
    loopb_d = 1'b0;
    up_d    = 1'b0;
    case (st_d)
      S_DETECT: rxdet_d = 1'b1;
      S_TRAIN: begin
        idle_d = 1'b0;
        if (cnt_d[3:0] == 4'd0) begin
          data_d  = 8'hBC;
          datak_d = 1'b1;
        end else begin
          data_d = 8'h4A;
        end
      end
      S_COMPLIANCE: begin
        idle_d = 1'b0;
        case (cnt_d[1:0])
          2'd0: begin data_d = 8'hBC; datak_d = 1'b1; comp_d = 1'b1; end
          2'd1: data_d = 8'hB5;
          2'd2: begin data_d = 8'hBC; datak_d = 1'b1; end
          default: data_d = 8'h4A;
        endcase
      end
      S_L0: begin
        idle_d  = 1'b0;
        up_d    = 1'b1;
        loopb_d = cfg_loopback;
        if (accept) begin
          data_d  = user_data;
          datak_d = user_datak;
        end
      end
      S_SKP: begin
        idle_d  = 1'b0;
        up_d    = 1'b1;
        loopb_d = cfg_loopback;
        datak_d = 1'b1;
        data_d  = (cnt_d[1:0] == 2'd0) ? 8'hBC : 8'h1C;
      end
      default: ;
    endcase
  end

  always_ff @(posedge TXCLK or negedge Reset) begin
    if (!Reset) begin
      st_q    <= S_ELEC_IDLE;
      cnt_q   <= '0;
      skp_q   <= '0;
      TXDATA  <= 8'h00;
      TXDATAK <= 1'b0;
      TXCOMP  <= 1'b0;
      TXIDLE  <= 1'b1;
      RXDET   <= 1'b0;
      RXLOOPB <= 1'b0;
      link_up <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      skp_q   <= skp_d;
      TXDATA  <= data_d;
      TXDATAK <= datak_d;
      TXCOMP  <= comp_d;
      TXIDLE  <= idle_d;
      RXDET   <= rxdet_d;
      RXLOOPB <= loopb_d;
      link_up <= up_d;
    end
  end

endmodule
